// File: rtl/psum_cdc_fifo_if.sv
// rtl/psum_cdc_fifo_if.sv - handshake/status bundle for the psum dual-clock FIFO
//
// Purpose: groups the write-side and read-side signals of psum_cdc_fifo.
//   slave  modport : the FIFO itself (takes requests, drives data and flags)
//   master modport : the producer/consumer side (drives requests, observes flags)
// Signals:
//   wr_en, wr_data                 write request and word (wr_clk domain)
//   full, almost_full, wr_count    write-side occupancy view
//   overflow                       sticky dropped-write flag
//   rd_en                          read request / FWFT pop acknowledge (rd_clk domain)
//   rd_data, rd_valid              read word and its qualifier
//   empty, almost_empty, rd_count  read-side occupancy view
//   underflow                      sticky read-while-empty flag
interface psum_cdc_fifo_if #(
  parameter int DW = 12,
  parameter int AW = 3
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_count;
  logic          overflow;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic          underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, wr_count, overflow,
    input  rd_data, rd_valid, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, wr_count, overflow,
    output rd_data, rd_valid, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/psum_cdc_fifo.sv
// rtl/psum_cdc_fifo.sv - dual-clock gray-pointer FIFO for PE-array partial sums
//
// Purpose: carries DW-bit partial sums from wr_clk to rd_clk. Binary pointers
// stay local; only registered gray copies cross, through SYNC flops each.
// Occupancy counts, almost thresholds and sticky error flags are provided in
// both domains; FWFT selects a prefetching output register.
// Ports:
//   wr_clk  write-domain clock
//   rd_clk  read-domain clock
//   reset   asynchronous active-high reset of both domains
//   fifo    psum_cdc_fifo_if.slave bundle (requests in, data and flags out)
module psum_cdc_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int SYNC  = 2,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic          wr_clk,
  input  logic          rd_clk,
  input  logic          reset,
  psum_cdc_fifo_if.slave fifo
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LP_AF_TH = (AW+1)'(AF_TH);
  localparam logic [AW:0] LP_AE_TH = (AW+1)'(AE_TH);
  localparam logic        LP_FWFT  = (FWFT != 0);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Storage: written in wr_clk, read in rd_clk; never reset, rd_valid qualifies it.
  logic [DW-1:0] r_mem [DEPTH];

  // Write domain
  logic [AW:0] r_wr_bin;
  logic [AW:0] r_wr_gray;
  logic [AW:0] r_wr_count;
  logic        r_full;
  logic        r_almost_full;
  logic        r_overflow;
  logic [AW:0] r_rd_gray_sync [SYNC];

  logic        w_wr_accept;
  logic [AW:0] w_wr_bin_next;
  logic [AW:0] w_wr_gray_next;
  logic [AW:0] w_rd_gray_w;
  logic        w_full_next;
  logic [AW:0] w_wr_count_next;

  // Read domain
  logic [AW:0]   r_rd_bin;
  logic [AW:0]   r_rd_gray;
  logic [AW:0]   r_rd_count;
  logic          r_mem_empty;
  logic          r_almost_empty;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_underflow;
  logic [AW:0]   r_wr_gray_sync [SYNC];

  logic        w_load;
  logic        w_rd_valid_next;
  logic        w_underflow_evt;
  logic [AW:0] w_rd_bin_next;
  logic [AW:0] w_rd_gray_next;
  logic [AW:0] w_wr_gray_r;
  logic [AW:0] w_rd_count_next;

  //--------------------------------------------------------------------------
  // Write side. Flags are registered from the post-write pointer so they move
  // on the same edge as the write; the synchronised read pointer lags, which
  // only ever over-reports occupancy.
  //--------------------------------------------------------------------------
  assign w_rd_gray_w     = r_rd_gray_sync[SYNC-1];
  assign w_wr_accept     = fifo.wr_en & ~r_full;
  assign w_wr_bin_next   = r_wr_bin + {{AW{1'b0}}, w_wr_accept};
  assign w_wr_gray_next  = bin2gray(w_wr_bin_next);
  // Full in gray: top two bits inverted, remainder equal (one lap ahead).
  assign w_full_next     = (w_wr_gray_next == {~w_rd_gray_w[AW:AW-1], w_rd_gray_w[AW-2:0]});
  assign w_wr_count_next = w_wr_bin_next - gray2bin(w_rd_gray_w);

  always_ff @(posedge wr_clk) begin
    if (w_wr_accept) r_mem[r_wr_bin[AW-1:0]] <= fifo.wr_data;
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      r_wr_count    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      for (int i = 0; i < SYNC; i++) r_rd_gray_sync[i] <= '0;
    end else begin
      r_wr_bin          <= w_wr_bin_next;
      r_wr_gray         <= w_wr_gray_next;
      r_wr_count        <= w_wr_count_next;
      r_full            <= w_full_next;
      r_almost_full     <= (w_wr_count_next >= LP_AF_TH);
      r_overflow        <= r_overflow | (fifo.wr_en & r_full);
      r_rd_gray_sync[0] <= r_rd_gray;
      for (int i = 1; i < SYNC; i++) r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
    end
  end

  //--------------------------------------------------------------------------
  // Read side. r_mem_empty tracks whether the memory itself holds a word.
  // In standard mode it is the empty flag; in FWFT mode it gates the prefetch
  // into the output register and empty is simply !rd_valid.
  //--------------------------------------------------------------------------
  assign w_wr_gray_r = r_wr_gray_sync[SYNC-1];

  always_comb begin
    w_load          = 1'b0;
    w_rd_valid_next = 1'b0;
    w_underflow_evt = 1'b0;
    if (LP_FWFT) begin
      // Refill when the output register is free or being popped this edge.
      w_load          = ~r_mem_empty & (~r_rd_valid | fifo.rd_en);
      w_rd_valid_next = w_load | (r_rd_valid & ~fifo.rd_en);
      w_underflow_evt = fifo.rd_en & ~r_rd_valid;
    end else begin
      w_load          = fifo.rd_en & ~r_mem_empty;
      w_rd_valid_next = w_load;
      w_underflow_evt = fifo.rd_en & r_mem_empty;
    end
    w_rd_bin_next   = r_rd_bin + {{AW{1'b0}}, w_load};
    w_rd_gray_next  = bin2gray(w_rd_bin_next);
    // In FWFT mode the word parked in the output register still counts.
    w_rd_count_next = gray2bin(w_wr_gray_r) - w_rd_bin_next
                      + {{AW{1'b0}}, LP_FWFT & w_rd_valid_next};
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      r_rd_count     <= '0;
      r_mem_empty    <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_underflow    <= 1'b0;
      for (int i = 0; i < SYNC; i++) r_wr_gray_sync[i] <= '0;
    end else begin
      r_rd_bin          <= w_rd_bin_next;
      r_rd_gray         <= w_rd_gray_next;
      r_rd_count        <= w_rd_count_next;
      r_mem_empty       <= (w_rd_gray_next == w_wr_gray_r);
      r_almost_empty    <= (w_rd_count_next <= LP_AE_TH);
      r_rd_valid        <= w_rd_valid_next;
      r_underflow       <= r_underflow | w_underflow_evt;
      if (w_load) r_rd_data <= r_mem[r_rd_bin[AW-1:0]];
      r_wr_gray_sync[0] <= r_wr_gray;
      for (int i = 1; i < SYNC; i++) r_wr_gray_sync[i] <= r_wr_gray_sync[i-1];
    end
  end

  assign fifo.full         = r_full;
  assign fifo.almost_full  = r_almost_full;
  assign fifo.wr_count     = r_wr_count;
  assign fifo.overflow     = r_overflow;
  assign fifo.rd_data      = r_rd_data;
  assign fifo.rd_valid     = r_rd_valid;
  assign fifo.empty        = LP_FWFT ? ~r_rd_valid : r_mem_empty;
  assign fifo.almost_empty = r_almost_empty;
  assign fifo.rd_count     = r_rd_count;
  assign fifo.underflow    = r_underflow;

endmodule

// File: tb/tb_psum_cdc_fifo.sv
// tb/tb_psum_cdc_fifo.sv - directed self-checking bench for psum_cdc_fifo
module tb_psum_cdc_fifo;
  localparam int DW = 12;
  localparam int AW = 3;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic reset  = 1'b1;
  int   wr_half = 5;
  int   rd_half = 7;
  int   errors = 0;
  int   checks = 0;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  psum_cdc_fifo_if #(.DW(DW), .AW(AW)) s_if ();
  psum_cdc_fifo_if #(.DW(DW), .AW(AW)) f_if ();

  psum_cdc_fifo #(.DW(DW), .DEPTH(8), .SYNC(2), .AF_TH(6), .AE_TH(2), .FWFT(0)) u_std (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .reset(reset), .fifo(s_if.slave));

  psum_cdc_fifo #(.DW(DW), .DEPTH(8), .SYNC(2), .AF_TH(6), .AE_TH(2), .FWFT(1)) u_fwft (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .reset(reset), .fifo(f_if.slave));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    s_if.wr_en = 1'b0; s_if.wr_data = '0; s_if.rd_en = 1'b0;
    f_if.wr_en = 1'b0; f_if.wr_data = '0; f_if.rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #3;
    reset = 1'b1;
    #200;
    reset = 1'b0;
    repeat (2) @(posedge wr_clk);
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  task automatic std_write(input logic [DW-1:0] d);
    s_if.wr_en = 1'b1; s_if.wr_data = d;
    @(posedge wr_clk); #1;
    s_if.wr_en = 1'b0;
  endtask

  task automatic std_read(output logic ok, output logic [DW-1:0] d);
    int n;
    n = 0; ok = 1'b0; d = '0;
    @(posedge rd_clk); #1;
    while (s_if.empty && n < 20) begin @(posedge rd_clk); #1; n++; end
    if (!s_if.empty) begin
      s_if.rd_en = 1'b1;
      @(posedge rd_clk); #1;
      s_if.rd_en = 1'b0;
      ok = s_if.rd_valid; d = s_if.rd_data;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #200;
    checks++; if (s_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", s_if.full); end
    checks++; if (s_if.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", s_if.almost_full); end
    checks++; if (s_if.wr_count !== 4'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", s_if.wr_count); end
    checks++; if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", s_if.overflow); end
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", s_if.empty); end
    checks++; if (s_if.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", s_if.almost_empty); end
    checks++; if (s_if.rd_count !== 4'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", s_if.rd_count); end
    checks++; if (s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", s_if.rd_valid); end
    checks++; if (s_if.rd_data !== 12'h000) begin errors++; $display("FAIL reset_rd_data: got %h want 000", s_if.rd_data); end
    checks++; if (s_if.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", s_if.underflow); end
    checks++; if (f_if.empty !== 1'b1 || f_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwft: empty=%b rd_valid=%b want 1/0", f_if.empty, f_if.rd_valid); end
    reset = 1'b0;
    repeat (2) @(posedge wr_clk);
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      std_write(DW'(i));
      checks++; if (s_if.wr_count !== 4'(i)) begin errors++; $display("FAIL fill_wr_count[%0d]: got %0d want %0d", i, s_if.wr_count, i); end
      checks++; if (s_if.almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, s_if.almost_full, (i >= 6)); end
      checks++; if (s_if.full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, s_if.full, (i == 8)); end
      if (i == 1) begin
        repeat (3) @(posedge rd_clk);
        #1;
        checks++; if (s_if.empty !== 1'b0) begin errors++; $display("FAIL write_to_empty_deassert: got empty=%b want 0", s_if.empty); end
      end
    end
    std_write(12'hFFF);
    checks++; if (s_if.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", s_if.overflow); end
    checks++; if (s_if.wr_count !== 4'd8 || s_if.full !== 1'b1) begin errors++; $display("FAIL overflow_dropped: count=%0d full=%b want 8/1", s_if.wr_count, s_if.full); end
    repeat (5) @(posedge wr_clk);
    #1;
    checks++; if (s_if.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", s_if.overflow); end
  endtask

  task automatic test_drain();
    logic ok;
    logic [DW-1:0] d;
    for (int i = 1; i <= 8; i++) begin
      std_read(ok, d);
      checks++; if (ok !== 1'b1 || d !== DW'(i)) begin errors++; $display("FAIL drain_word[%0d]: valid=%b data=%h want 1/%h", i, ok, d, DW'(i)); end
    end
    @(posedge rd_clk); #1;
    checks++; if (s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_pulse: got %b want 0", s_if.rd_valid); end
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", s_if.empty); end
    checks++; if (s_if.underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow: got %b want 0", s_if.underflow); end
    checks++; if (s_if.rd_count !== 4'd0) begin errors++; $display("FAIL drain_rd_count: got %0d want 0", s_if.rd_count); end
    repeat (4) @(posedge wr_clk);
    #1;
    checks++; if (s_if.full !== 1'b0 || s_if.wr_count !== 4'd0 || s_if.almost_full !== 1'b0) begin errors++; $display("FAIL drain_write_side: full=%b count=%0d af=%b want 0/0/0", s_if.full, s_if.wr_count, s_if.almost_full); end
  endtask

  task automatic test_underflow();
    @(posedge rd_clk); #1;
    s_if.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    s_if.rd_en = 1'b0;
    checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", s_if.underflow); end
    checks++; if (s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_rd_valid: got %b want 0", s_if.rd_valid); end
    checks++; if (s_if.rd_count !== 4'd0) begin errors++; $display("FAIL underflow_rd_count: got %0d want 0", s_if.rd_count); end
  endtask

  task automatic test_reset_mid_op();
    logic ok;
    logic [DW-1:0] d;
    for (int i = 0; i < 5; i++) std_write(DW'(12'h011 + i));
    repeat (5) @(posedge rd_clk);
    #1;
    checks++; if (s_if.rd_count !== 4'd5 || s_if.almost_empty !== 1'b0) begin errors++; $display("FAIL midop_queued: rd_count=%0d ae=%b want 5/0", s_if.rd_count, s_if.almost_empty); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (s_if.full !== 1'b0 || s_if.almost_full !== 1'b0 || s_if.wr_count !== 4'd0) begin errors++; $display("FAIL midop_wr_side: full=%b af=%b count=%0d want 0/0/0", s_if.full, s_if.almost_full, s_if.wr_count); end
    checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL midop_sticky: ovf=%b udf=%b want 0/0", s_if.overflow, s_if.underflow); end
    checks++; if (s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1 || s_if.rd_count !== 4'd0) begin errors++; $display("FAIL midop_rd_side: empty=%b ae=%b count=%0d want 1/1/0", s_if.empty, s_if.almost_empty, s_if.rd_count); end
    checks++; if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 12'h000) begin errors++; $display("FAIL midop_rd_data: valid=%b data=%h want 0/000", s_if.rd_valid, s_if.rd_data); end
    #200;
    reset = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    std_write(12'h0A5);
    std_write(12'h0A6);
    std_read(ok, d);
    checks++; if (ok !== 1'b1 || d !== 12'h0A5) begin errors++; $display("FAIL midop_first_read: valid=%b data=%h want 1/0a5", ok, d); end
    std_read(ok, d);
    checks++; if (ok !== 1'b1 || d !== 12'h0A6) begin errors++; $display("FAIL midop_second_read: valid=%b data=%h want 1/0a6", ok, d); end
  endtask

  task automatic test_stream(input int wh, input int rh, input logic [DW-1:0] base);
    int sent;
    int got;
    int bad;
    sent = 0; got = 0; bad = 0;
    wr_half = wh; rd_half = rh;
    apply_reset();
    fork
      begin
        int cyc = 0;
        while (sent < 100 && cyc < 5000) begin
          @(posedge wr_clk); #1; cyc++;
          if (!s_if.full && $urandom_range(0, 1) == 1) begin
            s_if.wr_en = 1'b1; s_if.wr_data = base + DW'(sent); sent++;
          end else begin
            s_if.wr_en = 1'b0;
          end
        end
        @(posedge wr_clk); #1;
        s_if.wr_en = 1'b0;
      end
      begin
        int cyc = 0;
        while (got < 100 && cyc < 5000) begin
          @(posedge rd_clk); #1; cyc++;
          if (s_if.rd_valid) begin
            if (s_if.rd_data !== base + DW'(got) && bad < 5) begin
              $display("FAIL stream_data[%0d]: got %h want %h", got, s_if.rd_data, base + DW'(got));
            end
            if (s_if.rd_data !== base + DW'(got)) bad++;
            got++;
          end
          s_if.rd_en = (got < 100 && !s_if.empty && $urandom_range(0, 1) == 1);
        end
        s_if.rd_en = 1'b0;
      end
    join
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_order: got %0d bad words want 0", bad); end
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count: got %0d words want 100", got); end
    checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL stream_errflags: ovf=%b udf=%b want 0/0", s_if.overflow, s_if.underflow); end
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
    #1;
    checks++; if (s_if.empty !== 1'b1 || s_if.wr_count !== 4'd0 || s_if.full !== 1'b0) begin errors++; $display("FAIL stream_quiesce: empty=%b count=%0d full=%b want 1/0/0", s_if.empty, s_if.wr_count, s_if.full); end
    wr_half = 5; rd_half = 7;
  endtask

  task automatic test_fwft();
    int n;
    apply_reset();
    f_if.wr_en = 1'b1; f_if.wr_data = 12'h0AB;
    @(posedge wr_clk); #1;
    f_if.wr_en = 1'b0;
    n = 0;
    while (!f_if.rd_valid && n < 10) begin @(posedge rd_clk); #1; n++; end
    checks++; if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== 12'h0AB) begin errors++; $display("FAIL fwft_prefetch: valid=%b data=%h want 1/0ab", f_if.rd_valid, f_if.rd_data); end
    checks++; if (f_if.empty !== 1'b0 || f_if.rd_count !== 4'd1) begin errors++; $display("FAIL fwft_head_flags: empty=%b count=%0d want 0/1", f_if.empty, f_if.rd_count); end
    f_if.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    f_if.rd_en = 1'b0;
    checks++; if (f_if.rd_valid !== 1'b0 || f_if.empty !== 1'b1) begin errors++; $display("FAIL fwft_pop: valid=%b empty=%b want 0/1", f_if.rd_valid, f_if.empty); end
  endtask

  task automatic test_fwft_back_to_back();
    logic [DW-1:0] exp_q [3];
    exp_q[0] = 12'h0C2; exp_q[1] = 12'h0C3; exp_q[2] = 12'h000;
    f_if.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_if.wr_data = 12'h0C1 + DW'(i);
      @(posedge wr_clk); #1;
    end
    f_if.wr_en = 1'b0;
    repeat (8) @(posedge rd_clk);
    #1;
    checks++; if (f_if.rd_count !== 4'd3 || f_if.rd_valid !== 1'b1 || f_if.rd_data !== 12'h0C1) begin errors++; $display("FAIL fwft_b2b_head: count=%0d valid=%b data=%h want 3/1/0c1", f_if.rd_count, f_if.rd_valid, f_if.rd_data); end
    f_if.rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge rd_clk); #1;
      if (k < 2) begin
        checks++; if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== exp_q[k]) begin errors++; $display("FAIL fwft_b2b_pop[%0d]: valid=%b data=%h want 1/%h", k, f_if.rd_valid, f_if.rd_data, exp_q[k]); end
      end else begin
        checks++; if (f_if.rd_valid !== 1'b0 || f_if.empty !== 1'b1) begin errors++; $display("FAIL fwft_b2b_end: valid=%b empty=%b want 0/1", f_if.rd_valid, f_if.empty); end
      end
    end
    f_if.rd_en = 1'b0;
    checks++; if (f_if.underflow !== 1'b0) begin errors++; $display("FAIL fwft_b2b_underflow: got %b want 0", f_if.underflow); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_underflow();
    test_reset_mid_op();
    test_stream(5, 15, 12'h100);
    test_stream(15, 5, 12'h200);
    test_fwft();
    test_fwft_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
